// File: rtl/stopwatch_timebase.sv
// Counting datapath for the stopwatch: prescales clk into count ticks and counts
// up/down/holds a 0..MAX_COUNT value, with BCD digits and wrap/expiry status.
module stopwatch_timebase #(
    parameter int TICK_DIV  = 4,
    parameter int MAX_COUNT = 99
) (
    input  logic       clk,
    input  logic       r,
    input  logic [1:0] q,
    input  logic       rstn,
    input  logic       ld,
    input  logic [6:0] fnum,
    output logic [6:0] num,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       wrap,
    output logic       done,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_UP   = 3'd1,
        RUN_DOWN = 3'd2,
        HOLD     = 3'd3,
        EXPIRED  = 3'd4
    } state_e;

    localparam logic [15:0] PS_LAST = 16'(TICK_DIV - 1);
    localparam logic [6:0]  MAX_V   = 7'(MAX_COUNT);

    state_e      state_q;
    logic [15:0] ps_q;
    logic [6:0]  num_q;
    logic        tick_q;
    logic        wrap_q;
    logic        done_q;

    // Mode code 2'b01 is illegal and folds into HOLD alongside 2'b11.
    function automatic state_e mode_state(input logic [1:0] m);
        case (m)
            2'b10:   return RUN_UP;
            2'b00:   return RUN_DOWN;
            default: return HOLD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            ps_q    <= '0;
            num_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (rstn) begin
                state_q <= IDLE;
                ps_q    <= '0;
                num_q   <= '0;
                done_q  <= 1'b0;
            end else if (ld) begin
                state_q <= mode_state(q);
                ps_q    <= '0;
                num_q   <= (fnum > MAX_V) ? MAX_V : fnum;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    RUN_UP, RUN_DOWN: begin
                        state_q <= mode_state(q);
                        if (ps_q == PS_LAST) begin
                            ps_q   <= '0;
                            tick_q <= 1'b1;
                            if (state_q == RUN_UP) begin
                                if (num_q >= MAX_V) begin
                                    num_q  <= '0;
                                    wrap_q <= 1'b1;
                                end else begin
                                    num_q <= num_q + 7'd1;
                                end
                            end else if (num_q <= 7'd1) begin
                                // Expiry overrides whatever mode the controller asked for.
                                num_q   <= '0;
                                done_q  <= 1'b1;
                                state_q <= EXPIRED;
                            end else begin
                                num_q <= num_q - 7'd1;
                            end
                        end else begin
                            ps_q <= ps_q + 16'd1;
                        end
                    end
                    EXPIRED: begin
                        if (q == 2'b10) begin
                            state_q <= RUN_UP;
                            done_q  <= 1'b0;
                        end
                    end
                    default: state_q <= mode_state(q);
                endcase
            end
        end
    end

    assign num     = num_q;
    assign tens    = 4'(num_q / 7'd10);
    assign ones    = 4'(num_q % 7'd10);
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule
